// File: rtl/mult_div_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package mult_div_pkg;

    // Controller states: iterate in MULT or DIV, then correct signs and commit in FIX.
    typedef enum logic [2:0] {
        StIdle,
        StMult,
        StDiv,
        StFix,
        StDone
    } md_state_t;

    // Number of Booth / restoring iterations (one per operand bit).
    localparam int unsigned MD_ITER = 32;

    // Exception code raised for divide-by-zero; also used by the exception address mux.
    localparam logic [31:0] EXC_DIV_ZERO = 32'd255;

endpackage

// File: rtl/mult_div_ctrl_if.sv
// Handshake and operand/result bundle between the main control unit and the mult/div unit.
interface mult_div_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Requester side (main control unit).
    modport master (
        output start_mult, start_div, a, b,
        input  busy, done, div_zero, hi, lo
    );

    // Arithmetic unit side.
    modport slave (
        input  start_mult, start_div, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/abs_neg32.sv
// Combinational 32-bit absolute value / conditional two's-complement negate.
// abs_mode = 1: res = |val| (negate when val is negative); otherwise negate when neg = 1.
module abs_neg32 (
    input  logic [31:0] val,
    input  logic        abs_mode,
    input  logic        neg,
    output logic [31:0] res
);
    logic do_neg;

    // Select the negate condition, then negate or pass through.
    always_comb begin
        do_neg = abs_mode ? val[31] : neg;
        res    = do_neg ? (~val + 32'd1) : val;
    end
endmodule

// File: rtl/mult_div_ctrl.sv
// Sequential signed multiply (Booth radix-2) / divide (restoring) unit with its controller.
// Results land in hi/lo on the FIX->DONE edge and are held until the next committed operation.
module mult_div_ctrl
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    mult_div_ctrl_if.slave       bus
);
    localparam logic [5:0] LastIter = 6'(MD_ITER - 1);

    md_state_t state_q, state_d;

    logic [5:0]       cnt_q;
    // Booth: {acc_hi, acc_lo, qm1} with one guard bit in acc_hi so a most-negative
    // multiplicand cannot overflow the add/subtract. Divide: acc_hi = remainder, acc_lo = quotient.
    logic [WIDTH:0]   acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic             qm1_q;
    logic [WIDTH-1:0] m_q;
    logic             is_div_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic             div_zero_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             last_iter;
    logic             b_zero;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    assign last_iter = (cnt_q == LastIter);
    assign b_zero    = (bus.b == '0);

    abs_neg32 u_abs_a (
        .val      (bus.a),
        .abs_mode (1'b1),
        .neg      (1'b0),
        .res      (abs_a)
    );

    abs_neg32 u_abs_b (
        .val      (bus.b),
        .abs_mode (1'b1),
        .neg      (1'b0),
        .res      (abs_b)
    );

    // Quotient is negative when operand signs differ.
    abs_neg32 u_fix_quot (
        .val      (acc_lo_q),
        .abs_mode (1'b0),
        .neg      (sign_a_q ^ sign_b_q),
        .res      (quot_fix)
    );

    // Remainder follows the sign of the dividend.
    abs_neg32 u_fix_rem (
        .val      (acc_hi_q[WIDTH-1:0]),
        .abs_mode (1'b0),
        .neg      (sign_a_q),
        .res      (rem_fix)
    );

    // Booth add/subtract of the sign-extended multiplicand, and restoring-divide trial subtract.
    always_comb begin
        booth_sum = acc_hi_q;
        unique case ({acc_lo_q[0], qm1_q})
            2'b01:   booth_sum = acc_hi_q + {m_q[WIDTH-1], m_q};
            2'b10:   booth_sum = acc_hi_q - {m_q[WIDTH-1], m_q};
            default: booth_sum = acc_hi_q;
        endcase
        div_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, m_q};
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; starts are only honoured in IDLE and multiply has priority.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start_mult) begin
                    state_d = StMult;
                end else if (bus.start_div && !b_zero) begin
                    state_d = StDiv;
                end
            end
            StMult:  if (last_iter) state_d = StFix;
            StDiv:   if (last_iter) state_d = StFix;
            StFix:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath: operand load, per-cycle iteration, and result commit in FIX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            qm1_q      <= 1'b0;
            m_q        <= '0;
            is_div_q   <= 1'b0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            div_zero_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start_mult) begin
                        acc_hi_q <= '0;
                        acc_lo_q <= bus.a;
                        qm1_q    <= 1'b0;
                        m_q      <= bus.b;
                        is_div_q <= 1'b0;
                        cnt_q    <= '0;
                    end else if (bus.start_div) begin
                        if (b_zero) begin
                            div_zero_q <= 1'b1;
                        end else begin
                            acc_hi_q <= '0;
                            acc_lo_q <= abs_a;
                            qm1_q    <= 1'b0;
                            m_q      <= abs_b;
                            sign_a_q <= bus.a[WIDTH-1];
                            sign_b_q <= bus.b[WIDTH-1];
                            is_div_q <= 1'b1;
                            cnt_q    <= '0;
                        end
                    end
                end
                StMult: begin
                    // Arithmetic shift right of {sum, Q, q-1}.
                    acc_hi_q <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    acc_lo_q <= {booth_sum[0], acc_lo_q[WIDTH-1:1]};
                    qm1_q    <= acc_lo_q[0];
                    cnt_q    <= last_iter ? '0 : cnt_q + 6'd1;
                end
                StDiv: begin
                    // Keep the trial difference unless it went negative (restore).
                    acc_hi_q <= div_trial[WIDTH] ? div_shift : div_trial;
                    acc_lo_q <= {acc_lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
                    cnt_q    <= last_iter ? '0 : cnt_q + 6'd1;
                end
                StFix: begin
                    if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end else begin
                        hi_q <= acc_hi_q[WIDTH-1:0];
                        lo_q <= acc_lo_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode registered state only; no path from starts or operands.
    assign bus.busy     = (state_q == StMult) || (state_q == StDiv) || (state_q == StFix);
    assign bus.done     = (state_q == StDone);
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule
